// File: rtl/boot_loader_ctrl_pkg.sv
// rtl/boot_loader_ctrl_pkg.sv - shared types and header layout for the boot loader
//
// Holds the loader FSM state type and the bit positions of the two word
// counts inside the stream header word. The CHK state exists only when
// LOADER_CHECKSUM_EN is defined.
package boot_loader_ctrl_pkg;

   // Header word layout: {I_CNT[31:16], D_CNT[15:0]}
   localparam int HDR_I_CNT_MSB = 31;
   localparam int HDR_I_CNT_LSB = 16;
   localparam int HDR_D_CNT_MSB = 15;
   localparam int HDR_D_CNT_LSB = 0;
   localparam int CNT_W         = HDR_I_CNT_MSB - HDR_I_CNT_LSB + 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HDR    = 3'd1,
      ST_LOAD_I = 3'd2,
      ST_LOAD_D = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_RUN    = 3'd5,
      ST_ERROR  = 3'd6
`ifdef LOADER_CHECKSUM_EN
      , ST_CHK  = 3'd7
`endif
   } state_e;

endpackage

// File: rtl/loader_addr_gen.sv
// rtl/loader_addr_gen.sv - per-region word counter with byte address and last-word flag
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   clr_i    in   clear the word counter (start of a new load)
//   inc_i    in   advance to the next word (one word accepted)
//   total_i  in   number of words in this region
//   addr_o   out  byte address of the current word, {count, 2'b00}
//   last_o   out  current word is the final word of the region
module loader_addr_gen #(
   parameter int CW = 10,
   parameter int TW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          inc_i,
   input  logic [TW-1:0] total_i,
   output logic [CW+1:0] addr_o,
   output logic          last_o
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign addr_o = {cnt_q, 2'b00};
   // Compared in 32 bits so a full-depth region cannot alias through counter wrap.
   assign last_o = (32'(cnt_q) + 32'd1) == 32'(total_i);

endmodule

// File: rtl/boot_loader_ctrl.sv
// rtl/boot_loader_ctrl.sv - stream-fed boot sequencer filling instruction then data BRAM
//
// Optional feature macro: LOADER_CHECKSUM_EN (adds CHK state and XOR trailer check).
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start                       1-cycle pulse in IDLE begins a load
//   s_dat/s_valid/s_ready       32-bit word stream, accepted on s_valid & s_ready
//   i_w_addr/dat/enb/byte_enb   instruction BRAM write port
//   d_w_addr/dat/enb/byte_enb   data BRAM write port
//   init_done                   hands data-BRAM write ownership to the CPU
//   pc_stall                    holds the PC until the load has completed
//   i_r_enb, rd_enbl            instruction BRAM / regfile read enables
//   busy                        load in progress (HDR..DRAIN)
//   error                       sticky load failure
module boot_loader_ctrl
   import boot_loader_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH    = 12,
   parameter int DATA_WIDTH    = 32,
   parameter int I_DEPTH_WORDS = 1024,
   parameter int D_DEPTH_WORDS = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] s_dat,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [ADDR_WIDTH-1:0] i_w_addr,
   output logic [DATA_WIDTH-1:0] i_w_dat,
   output logic                  i_w_enb,
   output logic [3:0]            i_w_byte_enb,
   output logic [ADDR_WIDTH-1:0] d_w_addr,
   output logic [DATA_WIDTH-1:0] d_w_dat,
   output logic                  d_w_enb,
   output logic [3:0]            d_w_byte_enb,
   output logic                  init_done,
   output logic                  pc_stall,
   output logic                  i_r_enb,
   output logic                  rd_enbl,
   output logic                  busy,
   output logic                  error
);

   localparam int CW = ADDR_WIDTH - 2;

`ifdef LOADER_CHECKSUM_EN
   localparam state_e ST_TAIL = ST_CHK;
`else
   localparam state_e ST_TAIL = ST_DRAIN;
`endif

   state_e state_q;
   state_e state_d;

   logic                  s_ready_q;
   logic                  busy_q;
   logic                  error_q;
   logic                  pc_stall_q;
   logic                  init_done_q;
   logic                  i_r_enb_q;
   logic                  rd_enbl_q;
   logic [CNT_W-1:0]      icnt_q;
   logic [CNT_W-1:0]      dcnt_q;
   logic [ADDR_WIDTH-1:0] i_w_addr_q;
   logic [DATA_WIDTH-1:0] i_w_dat_q;
   logic                  i_w_enb_q;
   logic [ADDR_WIDTH-1:0] d_w_addr_q;
   logic [DATA_WIDTH-1:0] d_w_dat_q;
   logic                  d_w_enb_q;
`ifdef LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] chk_q;
`endif

   logic                  accept;
   logic                  hdr_acc;
   logic                  i_inc;
   logic                  d_inc;
   logic [CNT_W-1:0]      hdr_icnt;
   logic [CNT_W-1:0]      hdr_dcnt;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic                  i_last;
   logic                  d_last;

   assign accept   = s_valid & s_ready_q;
   assign hdr_acc  = accept & (state_q == ST_HDR);
   assign i_inc    = accept & (state_q == ST_LOAD_I);
   assign d_inc    = accept & (state_q == ST_LOAD_D);
   assign hdr_icnt = s_dat[HDR_I_CNT_MSB:HDR_I_CNT_LSB];
   assign hdr_dcnt = s_dat[HDR_D_CNT_MSB:HDR_D_CNT_LSB];

   loader_addr_gen #(.CW(CW), .TW(CNT_W)) u_i_addr (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (hdr_acc),
      .inc_i   (i_inc),
      .total_i (icnt_q),
      .addr_o  (i_addr),
      .last_o  (i_last)
   );

   loader_addr_gen #(.CW(CW), .TW(CNT_W)) u_d_addr (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (hdr_acc),
      .inc_i   (d_inc),
      .total_i (dcnt_q),
      .addr_o  (d_addr),
      .last_o  (d_last)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_HDR;
         end
         ST_HDR: begin
            if (accept) begin
               if ((32'(hdr_icnt) > I_DEPTH_WORDS) || (32'(hdr_dcnt) > D_DEPTH_WORDS)) begin
                  state_d = ST_ERROR;
               end else if (hdr_icnt != '0) begin
                  state_d = ST_LOAD_I;
               end else if (hdr_dcnt != '0) begin
                  state_d = ST_LOAD_D;
               end else begin
                  state_d = ST_TAIL;
               end
            end
         end
         ST_LOAD_I: begin
            if (accept && i_last) state_d = (dcnt_q != '0) ? ST_LOAD_D : ST_TAIL;
         end
         ST_LOAD_D: begin
            if (accept && d_last) state_d = ST_TAIL;
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CHK: begin
            if (accept) state_d = (s_dat == chk_q) ? ST_DRAIN : ST_ERROR;
         end
`endif
         ST_DRAIN: state_d = ST_RUN;
         default:  state_d = state_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         s_ready_q   <= 1'b0;
         busy_q      <= 1'b0;
         error_q     <= 1'b0;
         pc_stall_q  <= 1'b1;
         init_done_q <= 1'b0;
         i_r_enb_q   <= 1'b0;
         rd_enbl_q   <= 1'b0;
         icnt_q      <= '0;
         dcnt_q      <= '0;
         i_w_addr_q  <= '0;
         i_w_dat_q   <= '0;
         i_w_enb_q   <= 1'b0;
         d_w_addr_q  <= '0;
         d_w_dat_q   <= '0;
         d_w_enb_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         chk_q       <= '0;
`endif
      end else begin
         state_q <= state_d;
         // Handshake/status follow the next state so s_ready is valid in the state's first cycle.
         busy_q    <= !(state_d inside {ST_IDLE, ST_RUN, ST_ERROR});
         s_ready_q <= !(state_d inside {ST_IDLE, ST_RUN, ST_ERROR, ST_DRAIN});
         error_q   <= (state_d == ST_ERROR);
         // Ownership hand-over lags RUN entry by one cycle, so the last write
         // has fully retired before the CPU takes the data BRAM.
         pc_stall_q  <= (state_q != ST_RUN);
         init_done_q <= (state_q == ST_RUN);
         i_r_enb_q   <= (state_q == ST_RUN);
         rd_enbl_q   <= (state_q == ST_RUN);
         if (hdr_acc) begin
            icnt_q <= hdr_icnt;
            dcnt_q <= hdr_dcnt;
         end
         i_w_enb_q <= i_inc;
         if (i_inc) begin
            i_w_addr_q <= i_addr;
            i_w_dat_q  <= s_dat;
         end
         d_w_enb_q <= d_inc;
         if (d_inc) begin
            d_w_addr_q <= d_addr;
            d_w_dat_q  <= s_dat;
         end
`ifdef LOADER_CHECKSUM_EN
         if (hdr_acc) begin
            chk_q <= s_dat;
         end else if (i_inc || d_inc) begin
            chk_q <= chk_q ^ s_dat;
         end
`endif
      end
   end

   assign s_ready      = s_ready_q;
   assign busy         = busy_q;
   assign error        = error_q;
   assign pc_stall     = pc_stall_q;
   assign init_done    = init_done_q;
   assign i_r_enb      = i_r_enb_q;
   assign rd_enbl      = rd_enbl_q;
   assign i_w_addr     = i_w_addr_q;
   assign i_w_dat      = i_w_dat_q;
   assign i_w_enb      = i_w_enb_q;
   assign i_w_byte_enb = {4{i_w_enb_q}};
   assign d_w_addr     = d_w_addr_q;
   assign d_w_dat      = d_w_dat_q;
   assign d_w_enb      = d_w_enb_q;
   assign d_w_byte_enb = {4{d_w_enb_q}};

endmodule
